// File: rtl/btn_pkg.sv
// Shared definitions for the button input-conditioning front end.
// Holds the button index map and the per-channel debounce FSM state encoding.
// No ports; imported by btn_debounce_ch and btn_event_gen.
package btn_pkg;

  // Button index map.
  localparam int BTN_CENTER = 0;
  localparam int BTN_TOP    = 1;
  localparam int BTN_BOTTOM = 2;
  localparam int BTN_LEFT   = 3;
  localparam int BTN_RIGHT  = 4;

  typedef enum logic [2:0] {
    LOCKED,
    IDLE,
    DEB_PRESS,
    HELD,
    DEB_RELEASE
  } deb_state_t;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: two-flop synchroniser, debounce counter and press/release FSM.
// Ports: clk, reset (sync, active-high), raw (async level in);
//        req (combinational, high for the cycle in which a press is accepted),
//        level (registered debounced level), level_nxt (value level takes at the next edge).
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic req,
  output logic level,
  output logic level_nxt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             s;
  logic [1:0]       warm;
  deb_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             at_last;
  logic             rel_done;

  assign at_last  = (cnt == CNT_LAST);

  // The press is accepted on the edge that moves DEB_PRESS -> HELD; the
  // request is decoded from the current state so the registered pulse in the
  // top level appears on that same edge.
  assign req      = (state == DEB_PRESS) && s && at_last;
  assign rel_done = (state == DEB_RELEASE) && !s && at_last;
  assign level_nxt = (level | req) & ~rel_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
      warm  <= 2'b00;
      state <= LOCKED;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync1 <= raw;
      s     <= sync1;
      // The synchroniser comes out of reset holding zeros, not the real
      // button level. LOCKED waits until both stages carry post-reset samples
      // so a button held through reset is seen as held and stays locked.
      warm  <= {warm[0], 1'b1};
      level <= level_nxt;

      unique case (state)
        LOCKED: begin
          if (warm[1] && !s) state <= IDLE;
        end
        IDLE: begin
          if (s) begin
            state <= DEB_PRESS;
            cnt   <= '0;
          end
        end
        DEB_PRESS: begin
          if (!s)           state <= IDLE;      // glitch rejected
          else if (at_last) state <= HELD;
          else              cnt   <= cnt + CNT_W'(1);
        end
        HELD: begin
          if (!s) begin
            state <= DEB_RELEASE;
            cnt   <= '0;
          end
        end
        DEB_RELEASE: begin
          if (s)            state <= HELD;      // bounce on release
          else if (at_last) state <= IDLE;
          else              cnt   <= cnt + CNT_W'(1);
        end
        default: state <= LOCKED;
      endcase
    end
  end

endmodule

// File: rtl/btn_event_gen.sv
// Input front end: debounced button press events (one-hot, lowest index wins,
// locked out while another button is held) plus two-flop synchronised switches.
// Ports: clk, reset; btn_raw/sw_raw async in; btn_pulse, btn_level, any_held, sw_sync registered out.
// DEBOUNCE_CYCLES must be >= 2.
module btn_event_gen
  import btn_pkg::*;
#(
  parameter  int N_BTN           = 5,
  parameter  int DEBOUNCE_CYCLES = 1000000,
  parameter  int N_SW            = 16,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [N_SW-1:0]  sw_raw,
  output logic [N_BTN-1:0] btn_pulse,
  output logic [N_BTN-1:0] btn_level,
  output logic             any_held,
  output logic [N_SW-1:0]  sw_sync
);

  logic [N_BTN-1:0] req;
  logic [N_BTN-1:0] lvl_nxt;
  logic [N_BTN-1:0] grant;
  logic             found;
  logic [N_SW-1:0]  sw_meta;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .raw      (btn_raw[i]),
      .req      (req[i]),
      .level    (btn_level[i]),
      .level_nxt(lvl_nxt[i])
    );
  end

  // A request is eligible only if no other button was held last cycle; the
  // lowest eligible index wins. Everything else is dropped for good, because
  // each channel raises its request only on the accepting edge.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < N_BTN; i++) begin
      if (req[i] && !found &&
          ((btn_level & ~(N_BTN'(1) << i)) == '0)) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_pulse <= '0;
      any_held  <= 1'b0;
      sw_meta   <= '0;
      sw_sync   <= '0;
    end else begin
      btn_pulse <= grant;
      any_held  <= |lvl_nxt;   // tracks btn_level on the same edge
      sw_meta   <= sw_raw;
      sw_sync   <= sw_meta;
    end
  end

endmodule
